// File: rtl/data_mem_initiator.sv
// MEM-stage data-memory initiator: holds strobes for LATENCY cycles, stalls, registers load data.
// Optional MISALIGN_CHECK_EN: misaligned requests skip the memory and flag misalign_o.
module data_mem_initiator #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             mis_q, mis_d;
  logic             req;
  logic             last;
  logic             misal;

  assign req  = MemRead_i | MemWrite_i;
  assign last = (cnt_q == LAST);

`ifdef MISALIGN_CHECK_EN
  assign misal = (addr_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = misal ? DONE : ACCESS;
      end
      ACCESS: begin
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (req && misal) begin
          mis_d = 1'b1;
        end else if (req) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          // a combined read+write request is performed as a store only
          wr_d    = MemWrite_i;
          rd_d    = MemRead_i & ~MemWrite_i;
          cnt_d   = '0;
          mis_d   = 1'b0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          if (rd_q) rdata_d = mem_rdata_i;
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          cnt_d = '0;
        end
      end
      DONE:    mis_d = 1'b0;
      default: mis_d = 1'b0;
    endcase
  end

  always_comb begin
    stall_o     = ((state_q == IDLE) && req) || (state_q == ACCESS);
    done_o      = (state_q == DONE);
`ifdef MISALIGN_CHECK_EN
    misalign_o  = (state_q == DONE) && mis_q;
`else
    misalign_o  = 1'b0;
`endif
    rdata_o     = rdata_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_read_o  = rd_q;
    mem_write_o = wr_q;
  end

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator at LATENCY=2.
// Build with MISALIGN_CHECK_EN to exercise the misaligned-access path.
module tb_data_mem_initiator;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        stall_o, done_o, misalign_o;
  logic        mem_read_o, mem_write_o;

  int vec = 0;
  int err = 0;

  data_mem_initiator #(.LATENCY(2), .CNT_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .misalign_o  (misalign_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Walk cycles until done_o, counting stall and strobe cycles (no judging here)
  task automatic observe(output int st, output int rdc, output int wrc,
                         output logic [31:0] a, output logic [31:0] d,
                         output bit stable, output bit seen);
    st = 0; rdc = 0; wrc = 0; a = '0; d = '0; stable = 1; seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_o === 1'b1) begin
        seen = 1;
        break;
      end
      if (stall_o === 1'b1) st++;
      if (mem_read_o === 1'b1 || mem_write_o === 1'b1) begin
        if (rdc + wrc == 0) begin
          a = mem_addr_o;
          d = mem_wdata_o;
        end else if (mem_addr_o !== a || mem_wdata_o !== d) begin
          stable = 0;
        end
        if (mem_read_o === 1'b1) rdc++;
        if (mem_write_o === 1'b1) wrc++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 0; MemRead_i = 0; MemWrite_i = 0;
    addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
    #2 rst_i = 1;
    #1;
    vec++;
    if ({rdata_o, mem_addr_o, mem_wdata_o} !== 96'h0) begin
      err++;
      $display("FAIL reset_data: got %h/%h/%h want 0", rdata_o, mem_addr_o, mem_wdata_o);
    end
    vec++;
    if ({stall_o, done_o, misalign_o, mem_read_o, mem_write_o} !== 5'b0) begin
      err++;
      $display("FAIL reset_ctl: got %b want 00000",
               {stall_o, done_o, misalign_o, mem_read_o, mem_write_o});
    end
    tick();
    tick();
    rst_i = 0;
    tick();
  endtask

  task automatic test_read();
    int st, rdc, wrc;
    logic [31:0] a, d;
    bit stable, seen;
    MemRead_i = 1; addr_i = 32'h10; mem_rdata_i = 32'hDEADBEEF;
    #1;
    observe(st, rdc, wrc, a, d, stable, seen);
    vec++;
    if (!seen) begin err++; $display("FAIL read_timeout: got no done want done"); end
    vec++;
    if (st != 3) begin err++; $display("FAIL read_stall: got %0d want 3", st); end
    vec++;
    if (rdc != 2 || wrc != 0) begin
      err++;
      $display("FAIL read_strobes: got rd=%0d wr=%0d want rd=2 wr=0", rdc, wrc);
    end
    vec++;
    if (a !== 32'h10 || !stable) begin
      err++;
      $display("FAIL read_addr: got %h stable=%0d want 00000010 stable=1", a, stable);
    end
    vec++;
    if (rdata_o !== 32'hDEADBEEF || stall_o !== 1'b0) begin
      err++;
      $display("FAIL read_done: got rdata=%h stall=%b want deadbeef 0", rdata_o, stall_o);
    end
    MemRead_i = 0;
    tick();
    vec++;
    if (done_o !== 1'b0) begin err++; $display("FAIL read_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_write();
    int st, rdc, wrc;
    logic [31:0] a, d;
    bit stable, seen;
    MemWrite_i = 1; addr_i = 32'h4; wdata_i = 32'h12345678; mem_rdata_i = 32'h55555555;
    #1;
    observe(st, rdc, wrc, a, d, stable, seen);
    vec++;
    if (!seen || st != 3) begin
      err++;
      $display("FAIL write_stall: got seen=%0d stall=%0d want 1 3", seen, st);
    end
    vec++;
    if (wrc != 2 || rdc != 0) begin
      err++;
      $display("FAIL write_strobes: got rd=%0d wr=%0d want rd=0 wr=2", rdc, wrc);
    end
    vec++;
    if (a !== 32'h4 || d !== 32'h12345678 || !stable) begin
      err++;
      $display("FAIL write_bus: got %h %h stable=%0d want 00000004 12345678 1", a, d, stable);
    end
    vec++;
    if (rdata_o !== 32'hDEADBEEF) begin
      err++;
      $display("FAIL write_rdata: got %h want deadbeef", rdata_o);
    end
    MemWrite_i = 0;
    tick();
    vec++;
    if (done_o !== 1'b0) begin err++; $display("FAIL write_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_both();
    int st, rdc, wrc;
    logic [31:0] a, d;
    bit stable, seen;
    MemRead_i = 1; MemWrite_i = 1; addr_i = 32'h8;
    wdata_i = 32'hCAFEF00D; mem_rdata_i = 32'h11111111;
    #1;
    observe(st, rdc, wrc, a, d, stable, seen);
    vec++;
    if (!seen || rdc != 0 || wrc != 2) begin
      err++;
      $display("FAIL both_strobes: got seen=%0d rd=%0d wr=%0d want 1 0 2", seen, rdc, wrc);
    end
    vec++;
    if (rdata_o !== 32'hDEADBEEF) begin
      err++;
      $display("FAIL both_rdata: got %h want deadbeef", rdata_o);
    end
    MemRead_i = 0; MemWrite_i = 0;
    tick();
    vec++;
    if (mem_addr_o !== 32'h8 || mem_wdata_o !== 32'hCAFEF00D || mem_write_o !== 1'b0) begin
      err++;
      $display("FAIL idle_retain: got %h %h wr=%b want 00000008 cafef00d 0",
               mem_addr_o, mem_wdata_o, mem_write_o);
    end
  endtask

  task automatic test_abort();
    MemRead_i = 1; addr_i = 32'h20; mem_rdata_i = 32'h77777777;
    tick();
    tick();
    vec++;
    if (mem_read_o !== 1'b1) begin
      err++;
      $display("FAIL abort_pre: got %b want 1", mem_read_o);
    end
    #2 rst_i = 1;
    #1;
    vec++;
    if (mem_read_o !== 1'b0 || rdata_o !== 32'h0) begin
      err++;
      $display("FAIL abort_drop: got rd=%b rdata=%h want 0 0", mem_read_o, rdata_o);
    end
    MemRead_i = 0;
    #1;
    vec++;
    if (stall_o !== 1'b0) begin err++; $display("FAIL abort_stall: got %b want 0", stall_o); end
    tick();
    rst_i = 0;
    tick();
    vec++;
    if (done_o !== 1'b0) begin err++; $display("FAIL abort_done: got %b want 0", done_o); end
  endtask

  task automatic test_back_to_back();
    int st, rdc, wrc;
    logic [31:0] a, d;
    bit stable, seen;
    MemRead_i = 1; addr_i = 32'h0; mem_rdata_i = 32'hA5A50000;
    #1;
    observe(st, rdc, wrc, a, d, stable, seen);
    vec++;
    if (!seen || rdata_o !== 32'hA5A50000 || a !== 32'h0) begin
      err++;
      $display("FAIL b2b_first: got seen=%0d rdata=%h addr=%h want 1 a5a50000 0",
               seen, rdata_o, a);
    end
    addr_i = 32'h4; mem_rdata_i = 32'h00005A5A;
    tick();
    vec++;
    if (done_o !== 1'b0 || stall_o !== 1'b1 || mem_read_o !== 1'b0) begin
      err++;
      $display("FAIL b2b_idle: got done=%b stall=%b rd=%b want 0 1 0",
               done_o, stall_o, mem_read_o);
    end
    observe(st, rdc, wrc, a, d, stable, seen);
    vec++;
    if (!seen || st != 3 || rdc != 2) begin
      err++;
      $display("FAIL b2b_second: got seen=%0d stall=%0d rd=%0d want 1 3 2", seen, st, rdc);
    end
    vec++;
    if (rdata_o !== 32'h00005A5A || a !== 32'h4) begin
      err++;
      $display("FAIL b2b_data: got rdata=%h addr=%h want 00005a5a 00000004", rdata_o, a);
    end
    MemRead_i = 0;
    tick();
  endtask

  task automatic test_misalign();
    int st, rdc, wrc;
    logic [31:0] a, d;
    bit stable, seen;
    MemRead_i = 1; addr_i = 32'h6; mem_rdata_i = 32'h0BADF00D;
    #1;
    observe(st, rdc, wrc, a, d, stable, seen);
`ifdef MISALIGN_CHECK_EN
    vec++;
    if (!seen || st != 1 || rdc != 0) begin
      err++;
      $display("FAIL mis_path: got seen=%0d stall=%0d rd=%0d want 1 1 0", seen, st, rdc);
    end
    vec++;
    if (misalign_o !== 1'b1 || rdata_o !== 32'h00005A5A) begin
      err++;
      $display("FAIL mis_flag: got mis=%b rdata=%h want 1 00005a5a", misalign_o, rdata_o);
    end
`else
    vec++;
    if (!seen || rdc != 2 || a !== 32'h6) begin
      err++;
      $display("FAIL mis_issue: got seen=%0d rd=%0d addr=%h want 1 2 00000006", seen, rdc, a);
    end
    vec++;
    if (misalign_o !== 1'b0 || rdata_o !== 32'h0BADF00D) begin
      err++;
      $display("FAIL mis_flag: got mis=%b rdata=%h want 0 0badf00d", misalign_o, rdata_o);
    end
`endif
    MemRead_i = 0;
    tick();
    vec++;
    if (done_o !== 1'b0 || misalign_o !== 1'b0) begin
      err++;
      $display("FAIL mis_pulse: got done=%b mis=%b want 0 0", done_o, misalign_o);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_both();
    test_abort();
    test_back_to_back();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
